// File: rtl/risc_v_single_cycle.sv
// Single-cycle RV32I core with one unified 256-word instruction/data memory.
// Clock and reset are its only ports; fetch/decode/execute/mem scopes expose its state.
module risc_v_single_cycle (
  input logic clk,
  input logic reset
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [31:0] wb_data;

  if (1'b1) begin : fetch
    logic [31:0] PC;
    logic [31:0] instr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) PC <= '0;
      else        PC <= execute.next_pc;
    end

    assign instr = mem.mem[PC[9:2]];
  end

  if (1'b1) begin : mem
    logic [31:0] mem [0:255];
    logic        MemWrite;
    logic [7:0]  word_idx;
    logic [31:0] rdata;

    assign MemWrite = decode.MemWrite & reset;
    assign word_idx = execute.ALU_result[9:2];
    assign rdata    = decode.MemRead ? mem[word_idx] : '0;

    // NOTE: the memory array has no reset so contents preloaded while reset is held survive;
    // a plain edge process keeps it open to hierarchical preload writes.
    always @(posedge clk) begin
      if (MemWrite) mem[word_idx] <= decode.read_data2;
    end
  end

  if (1'b1) begin : decode
    logic [31:0] reg_file [0:31];
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [31:0] read_data1, read_data2;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, imm;
    logic        RegWrite, MemRead, MemWrite, ALUSrc, Branch, MemtoReg, Jump, AUIPC;
    logic        is_jalr, is_lui;
    alu_op_e     alu_op;

    assign opcode = fetch.instr[6:0];
    assign rd     = fetch.instr[11:7];
    assign funct3 = fetch.instr[14:12];
    assign rs1    = fetch.instr[19:15];
    assign rs2    = fetch.instr[24:20];

    assign i_imm = {{20{fetch.instr[31]}}, fetch.instr[31:20]};
    assign s_imm = {{20{fetch.instr[31]}}, fetch.instr[31:25], fetch.instr[11:7]};
    assign b_imm = {{19{fetch.instr[31]}}, fetch.instr[31], fetch.instr[7],
                    fetch.instr[30:25], fetch.instr[11:8], 1'b0};
    assign u_imm = {fetch.instr[31:12], 12'b0};
    assign j_imm = {{11{fetch.instr[31]}}, fetch.instr[31], fetch.instr[19:12],
                    fetch.instr[20], fetch.instr[30:21], 1'b0};

    always_comb begin
      // NOTE: every output gets a default first, so no decode path can infer a latch.
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      ALUSrc   = 1'b0;
      Branch   = 1'b0;
      MemtoReg = 1'b0;
      Jump     = 1'b0;
      AUIPC    = 1'b0;
      is_jalr  = 1'b0;
      is_lui   = 1'b0;
      alu_op   = ALU_ADD;
      imm      = i_imm;
      case (opcode)
        OP_R: begin
          RegWrite = 1'b1;
          alu_op   = alu_sel(funct3, fetch.instr[30]);
        end
        OP_I: begin
          RegWrite = 1'b1;
          ALUSrc   = 1'b1;
          alu_op   = alu_sel(funct3, (funct3 == 3'b101) & fetch.instr[30]);
        end
        OP_LOAD: begin
          RegWrite = 1'b1;
          MemRead  = 1'b1;
          MemtoReg = 1'b1;
          ALUSrc   = 1'b1;
        end
        OP_STORE: begin
          MemWrite = 1'b1;
          ALUSrc   = 1'b1;
          imm      = s_imm;
        end
        OP_BRANCH: begin
          Branch = 1'b1;
          imm    = b_imm;
        end
        OP_JAL: begin
          RegWrite = 1'b1;
          Jump     = 1'b1;
          imm      = j_imm;
        end
        OP_JALR: begin
          RegWrite = 1'b1;
          Jump     = 1'b1;
          is_jalr  = 1'b1;
          ALUSrc   = 1'b1;
        end
        OP_LUI: begin
          RegWrite = 1'b1;
          is_lui   = 1'b1;
          imm      = u_imm;
        end
        OP_AUIPC: begin
          RegWrite = 1'b1;
          AUIPC    = 1'b1;
          imm      = u_imm;
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < 32; i++) reg_file[i] <= '0;
      end else if (RegWrite && rd != 5'd0) begin
        reg_file[rd] <= wb_data;
      end
    end

    assign read_data1 = (rs1 == 5'd0) ? '0 : reg_file[rs1];
    assign read_data2 = (rs2 == 5'd0) ? '0 : reg_file[rs2];
  end

  if (1'b1) begin : execute
    logic [31:0] op_a, op_b;
    logic [31:0] ALU_result;
    logic [31:0] branch_target, pc_plus4, next_pc;
    logic        cond, branch_taken;

    assign op_a = decode.read_data1;
    assign op_b = decode.ALUSrc ? decode.imm : decode.read_data2;

    always_comb begin
      ALU_result = '0;
      case (decode.alu_op)
        ALU_ADD:  ALU_result = op_a + op_b;
        ALU_SUB:  ALU_result = op_a - op_b;
        ALU_SLL:  ALU_result = op_a << op_b[4:0];
        ALU_SLT:  ALU_result = {31'b0, $signed(op_a) < $signed(op_b)};
        ALU_SLTU: ALU_result = {31'b0, op_a < op_b};
        ALU_XOR:  ALU_result = op_a ^ op_b;
        ALU_SRL:  ALU_result = op_a >> op_b[4:0];
        ALU_SRA:  ALU_result = $unsigned($signed(op_a) >>> op_b[4:0]);
        ALU_OR:   ALU_result = op_a | op_b;
        ALU_AND:  ALU_result = op_a & op_b;
        default:  ALU_result = '0;
      endcase
    end

    // Branches compare the two register operands directly, independent of the ALU.
    always_comb begin
      case (decode.funct3)
        3'b000:  cond = (decode.read_data1 == decode.read_data2);
        3'b001:  cond = (decode.read_data1 != decode.read_data2);
        3'b100:  cond = ($signed(decode.read_data1) <  $signed(decode.read_data2));
        3'b101:  cond = ($signed(decode.read_data1) >= $signed(decode.read_data2));
        3'b110:  cond = (decode.read_data1 <  decode.read_data2);
        3'b111:  cond = (decode.read_data1 >= decode.read_data2);
        default: cond = 1'b0;
      endcase
    end

    assign branch_taken  = decode.Branch & cond;
    assign branch_target = fetch.PC + decode.b_imm;
    assign pc_plus4      = fetch.PC + 32'd4;

    always_comb begin
      if (branch_taken)        next_pc = branch_target;
      else if (decode.is_jalr) next_pc = {ALU_result[31:1], 1'b0};
      else if (decode.Jump)    next_pc = fetch.PC + decode.imm;
      else                     next_pc = pc_plus4;
    end
  end

  always_comb begin
    if (decode.Jump)          wb_data = execute.pc_plus4;
    else if (decode.is_lui)   wb_data = decode.imm;
    else if (decode.AUIPC)    wb_data = fetch.PC + decode.imm;
    else if (decode.MemtoReg) wb_data = mem.rdata;
    else                      wb_data = execute.ALU_result;
  end

endmodule

// File: tb/tb_risc_v_single_cycle.sv
// Bench for risc_v_single_cycle: an instruction-level model of RV32I tracks the
// architectural state and is compared against the core every cycle, plus directed literals.
`timescale 1ns/1ps
module tb_risc_v_single_cycle;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic cmp_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] m_mem [0:255];
  logic [31:0] m_reg [0:31];
  logic [31:0] m_pc;
  logic [31:0] prog [0:15];

  risc_v_single_cycle dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  function automatic logic [31:0] imm_i(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction
  function automatic logic [31:0] imm_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: if (alt) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic br_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = '0;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, res, npc, addr;
    logic wr;
    ins  = m_mem[m_pc[9:2]];
    a    = m_reg[ins[19:15]];
    b    = m_reg[ins[24:20]];
    res  = '0;
    addr = '0;
    wr   = 1'b0;
    npc  = m_pc + 32'd4;
    case (ins[6:0])
      7'h33: begin wr = 1'b1; res = alu(ins[14:12], ins[30], a, b); end
      7'h13: begin wr = 1'b1; res = alu(ins[14:12], (ins[14:12] == 3'd5) && ins[30], a, imm_i(ins)); end
      7'h03: begin addr = a + imm_i(ins); wr = 1'b1; res = m_mem[addr[9:2]]; end
      7'h23: begin addr = a + imm_s(ins); m_mem[addr[9:2]] = b; end
      7'h63: if (br_cond(ins[14:12], a, b)) npc = m_pc + imm_b(ins);
      7'h6f: begin wr = 1'b1; res = m_pc + 32'd4; npc = m_pc + imm_j(ins); end
      7'h67: begin wr = 1'b1; res = m_pc + 32'd4; addr = a + imm_i(ins); npc = {addr[31:1], 1'b0}; end
      7'h37: begin wr = 1'b1; res = {ins[31:12], 12'b0}; end
      7'h17: begin wr = 1'b1; res = m_pc + {ins[31:12], 12'b0}; end
      default: ;
    endcase
    if (wr && ins[11:7] != 5'd0) m_reg[ins[11:7]] = res;
    m_pc = npc;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] ins, a, b;
      ins = m_mem[m_pc[9:2]];
      a   = m_reg[ins[19:15]];
      b   = m_reg[ins[24:20]];
      check("pc", dut.fetch.PC, m_pc);
      for (int i = 0; i < 32; i++) check($sformatf("x%0d", i), dut.decode.reg_file[i], m_reg[i]);
      for (int i = 0; i < 256; i++) check($sformatf("mem[%0d]", i), dut.mem.mem[i], m_mem[i]);
      check("branch_target", dut.execute.branch_target, m_pc + imm_b(ins));
      check("branch_taken", {31'b0, dut.execute.branch_taken},
            {31'b0, (ins[6:0] == 7'h63) && br_cond(ins[14:12], a, b)});
      check("mem_write", {31'b0, dut.mem.MemWrite}, {31'b0, reset && (ins[6:0] == 7'h23)});
    end
  end

  task automatic load_word(input int idx, input logic [31:0] w);
    dut.mem.mem[idx] = w;
    m_mem[idx] = w;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3 reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    prog = '{32'h00500093,   // addi x1,x0,5
             32'h00300113,   // addi x2,x0,3
             32'h002081b3,   // add  x3,x1,x2
             32'h04302023,   // sw   x3,64(x0)
             32'h04002203,   // lw   x4,64(x0)
             32'h00418463,   // beq  x3,x4,+8
             32'h00100293,   // addi x5,x0,1 (skipped)
             32'hfff00313,   // addi x6,x0,-1
             32'h006033b3,   // sltu x7,x0,x6
             32'h40435413,   // srai x8,x6,4
             32'h00700013,   // addi x0,x0,7
             32'h123454b7,   // lui  x9,0x12345
             32'h00001517,   // auipc x10,1   (pc 0x30)
             32'h000325b3,   // slt  x11,x6,x0
             32'h03d00667,   // jalr x12,61(x0) -> 0x3c
             32'h0000006f};  // jal  x0,0 (halt)
    model_reset();
    for (int i = 0; i < 256; i++) load_word(i, 32'h0);
    for (int i = 0; i < 16; i++)  load_word(i, prog[i]);

    @(posedge clk); #1;
    check("reset_pc", dut.fetch.PC, 32'h0);
    check("reset_x1", dut.decode.reg_file[1], 32'h0);
    cmp_en = 1'b1;

    release_reset();
    repeat (3) @(posedge clk);
    #1;
    check("x1_5", dut.decode.reg_file[1], 32'd5);
    check("x2_3", dut.decode.reg_file[2], 32'd3);
    check("x3_8", dut.decode.reg_file[3], 32'd8);
    check("pc_0c", dut.fetch.PC, 32'h0c);
    check("model_x3", m_reg[3], 32'd8);
    check("store_memwrite", {31'b0, dut.mem.MemWrite}, 32'd1);
    check("store_alu", dut.execute.ALU_result, 32'h40);

    @(posedge clk); #1;
    check("mem16_8", dut.mem.mem[16], 32'd8);
    check("model_mem16", m_mem[16], 32'd8);

    @(posedge clk); #1;
    check("x4_8", dut.decode.reg_file[4], 32'd8);
    check("beq_taken", {31'b0, dut.execute.branch_taken}, 32'd1);
    check("pc_14", dut.fetch.PC, 32'h14);

    @(posedge clk); #1;
    check("pc_jump8", dut.fetch.PC, 32'h1c);

    repeat (8) @(posedge clk);
    #1;
    check("pc_halt", dut.fetch.PC, 32'h3c);
    check("x5_skipped", dut.decode.reg_file[5], 32'd0);
    check("x6_m1", dut.decode.reg_file[6], 32'hffffffff);
    check("x7_sltu", dut.decode.reg_file[7], 32'd1);
    check("x8_srai", dut.decode.reg_file[8], 32'hffffffff);
    check("x0_zero", dut.decode.reg_file[0], 32'd0);
    check("x9_lui", dut.decode.reg_file[9], 32'h12345000);
    check("x10_auipc", dut.decode.reg_file[10], 32'h00001030);
    check("x11_slt", dut.decode.reg_file[11], 32'd1);
    check("x12_jalr", dut.decode.reg_file[12], 32'h3c);
    check("model_x8", m_reg[8], 32'hffffffff);
    check("model_pc", m_pc, 32'h3c);
    repeat (2) begin
      @(posedge clk); #1;
      check("pc_hold", dut.fetch.PC, 32'h3c);
    end

    // Restart, run partway, then abort with a one-cycle reset.
    reset = 1'b0;
    release_reset();
    repeat (5) @(posedge clk);
    #1;
    check("pc_mid", dut.fetch.PC, 32'h14);
    reset = 1'b0;
    #1;
    check("midreset_pc", dut.fetch.PC, 32'h0);
    for (int i = 0; i < 32; i++) check($sformatf("midreset_x%0d", i), dut.decode.reg_file[i], 32'h0);
    check("midreset_mem16", dut.mem.mem[16], 32'd8);
    check("midreset_mem0", dut.mem.mem[0], 32'h00500093);
    release_reset();
    @(posedge clk); #1;
    check("restart_pc", dut.fetch.PC, 32'h04);
    check("restart_x1", dut.decode.reg_file[1], 32'd5);
    repeat (13) @(posedge clk);
    #1;
    check("rerun_pc", dut.fetch.PC, 32'h3c);
    check("rerun_x4", dut.decode.reg_file[4], 32'd8);
    check("rerun_x12", dut.decode.reg_file[12], 32'h3c);
    check("rerun_x5", dut.decode.reg_file[5], 32'd0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/risc_v_single_cycle.md
RISC_V_SINGLE_CYCLE -- requirements
Module: risc_v_single_cycle

Interface
REQ-001 The block SHALL have one clock and a reset that is asynchronous and active-low.
REQ-002 The block SHALL have these ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
REQ-003 The block SHALL have no other ports; state is observed through these internal names:
- fetch.PC, fetch.instr
- decode.reg_file[0:31], decode.read_data2
- decode control signals RegWrite, MemRead, MemWrite, ALUSrc, Branch, MemtoReg, Jump, AUIPC, funct3
- execute.ALU_result, execute.branch_taken, execute.branch_target
- mem.mem[0:255], mem.MemWrite

Function
REQ-004 Each instruction SHALL complete in exactly one clk cycle; PC, register file and memory SHALL update only on the rising clk edge while reset is deasserted.
REQ-005 Memory SHALL be one unified instruction/data array: 256 x 32-bit words, word index = address[9:2], upper address bits ignored.
REQ-006 Memory reads (fetch and load) SHALL be combinational; stores SHALL be written on the rising edge.
REQ-007 A store to a word SHALL be visible to a fetch or load of that word from the next cycle onward.
REQ-008 The register file SHALL be 32 x 32-bit with two combinational read ports and one write port; x0 SHALL always read 0, and writes to x0 SHALL be discarded.
REQ-009 Supported RV32I instructions:
- R-type: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU
- I-type: ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI
- LW, SW
- BEQ, BNE, BLT, BGE, BLTU, BGEU
- JAL, JALR, LUI, AUIPC
REQ-010 Immediates SHALL be sign-extended per RV32I I/S/B/U/J formats; shift amount = low 5 bits; arithmetic wraps modulo 2^32 with no overflow trap.
REQ-011 Loads SHALL return the full 32-bit word regardless of funct3; stores SHALL write the full word regardless of funct3; address = rs1 + imm.
REQ-012 Next PC selection:
- taken branch: PC + B-imm
- JAL: PC + J-imm
- JALR: (rs1 + imm) with bit0 cleared
- otherwise: PC + 4
REQ-013 JAL and JALR SHALL write PC+4 to rd; LUI SHALL write the U-imm; AUIPC SHALL write PC + U-imm.
REQ-014 branch_target SHALL always equal PC + B-imm; branch_taken SHALL be 1 only for a branch whose condition holds.
REQ-015 Signed compares SHALL apply to BLT/BGE/SLT(I); unsigned compares SHALL apply to BLTU/BGEU/SLTU/SLTIU.
REQ-016 An unrecognised opcode, including 0x00000000, SHALL execute as a NOP: no register or memory write, PC+4.
REQ-017 JAL x0,0 (0x0000006f) SHALL hold PC constant; this is the halt idiom.

Reset
REQ-018 While reset=0:
- PC SHALL be 0x00000000 immediately, independent of clk.
- All registers SHALL be cleared to 0.
- No memory write SHALL occur.
REQ-019 Memory contents SHALL NOT be affected by reset, so preloads made during reset are retained.
REQ-020 After reset rises, the first clk edge SHALL execute mem[0].
REQ-021 Reset asserted mid-program SHALL abort the program and restart it from PC 0 on release.

Verification
REQ-022 Load mem[0..2] = 00500093, 00300113, 002081b3 and release reset -> after 3 edges x1=5, x2=3, x3=8, PC=0x0c.
REQ-023 Continue with SW x3,64(x0) (04302023) then LW x4,64(x0) (04002203):
- At the store edge, mem.MemWrite=1 and ALU_result=0x40.
- Afterwards mem[16]=8 and x4=8.
REQ-024 Continue with:
- BEQ x3,x4,+8 (00418463) -> branch_taken=1 and PC jumps by 8.
- The skipped ADDI x5,x0,1 (00100293) -> x5 stays 0.
- Then JAL x0,0 (0000006f) -> PC unchanged on consecutive edges.
REQ-025 ADDI x0,x0,7 (00700013) -> x0 reads 0.
REQ-026 Negative-value checks:
- ADDI x6,x0,-1 (fff00313), then SLTU x7,x0,x6 (006033b3) -> x7=1.
- SRAI x8,x6,4 (40435413) -> x8=0xffffffff.
REQ-027 Assert reset for 1 cycle mid-program -> PC=0 and all registers 0 immediately; memory unchanged; execution restarts at mem[0].
